fft_stream_bridge: RTL
======================

FFT_STREAM_BRIDGE -- requirements
Module: fft_stream_bridge

Interface
REQ-001 Parameter IN_WIDTH, default 16: input sample width.
REQ-002 Parameter OUT_WIDTH, default 32: result word width.
REQ-003 Parameter ADDR_WIDTH, default 10: sample RAM address width; buffer depth DEPTH = 2**ADDR_WIDTH.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 n_Reset  in  1  asynchronous, active-low reset.
REQ-006 START  in  1  one-cycle request to begin a frame; accepted only in IDLE.
REQ-007 SAMP_NUMBER  in  ADDR_WIDTH+1  samples per frame; sampled on accepted START.
REQ-008 RDATA / RVALID / RREADY  in IN_WIDTH / in 1 / out 1  input sample stream.
REQ-009 WDATA / WVALID / WREADY / WLAST  out OUT_WIDTH / out 1 / in 1 / out 1  result stream; WLAST marks final word.
REQ-010 RAM_ADDR  out  ADDR_WIDTH; RAM_WDATA  out  IN_WIDTH; RAM_WE  out 1; RAM_RE  out 1; RAM_RDATA  in  OUT_WIDTH  sample/result RAM port, read latency exactly 1 cycle.
REQ-011 DATA_LOADED  out  1  one-cycle pulse when last sample written.
REQ-012 CALC_END  in  1  level/pulse from FFT core: results ready in RAM.
REQ-013 BUSY  out  1  high in every state except IDLE; ERR  out  1  one-cycle pulse on rejected START.

Function
REQ-014 States SHALL be IDLE, LOAD, WAIT_CALC, RD, HOLD; encoding free.
REQ-015 IDLE: on START with SAMP_NUMBER = 0 -> stay IDLE, pulse ERR next cycle; otherwise latch N = min(SAMP_NUMBER, DEPTH), clear index, -> LOAD.
REQ-016 START outside IDLE SHALL be ignored (no ERR).
REQ-017 LOAD: RREADY = 1; each cycle with RVALID & RREADY: RAM_WE = 1, RAM_ADDR = index, RAM_WDATA = RDATA (combinational, same cycle), index++.
REQ-018 On the transfer with index = N-1: DATA_LOADED pulses the following cycle, index cleared, -> WAIT_CALC; RREADY SHALL be 0 from that next cycle.
REQ-019 RVALID low in LOAD: no write, index holds, no timeout.
REQ-020 WAIT_CALC: RREADY = 0, WVALID = 0; CALC_END = 1 -> RD next cycle; CALC_END in any other state ignored.
REQ-021 RD: RAM_RE = 1, RAM_ADDR = index for exactly one cycle, -> HOLD.
REQ-022 HOLD: output register captured from RAM_RDATA on entry cycle; WVALID = 1, WDATA = register, WLAST = (index = N-1); WDATA/WLAST stable while WVALID & !WREADY.
REQ-023 HOLD with WREADY: if index = N-1 -> IDLE, else index++, -> RD; throughput one word per 2 cycles.
REQ-024 Index counter SHALL be ADDR_WIDTH+1 bits; no wrap-around possible since N <= DEPTH; N = DEPTH writes addresses 0..DEPTH-1 exactly once.
REQ-025 N = 1: single write, DATA_LOADED, single output word with WLAST = 1.
REQ-026 RAM_WE and RAM_RE SHALL never be high in the same cycle; both 0 outside LOAD/RD.

Reset
REQ-027 n_Reset low SHALL immediately force IDLE, index = 0, N = 0, output register = 0.
REQ-028 During reset all outputs 0: RREADY, WVALID, WLAST, RAM_WE, RAM_RE, DATA_LOADED, ERR, BUSY, WDATA, RAM_ADDR, RAM_WDATA.
REQ-029 Reset mid-frame (any state) SHALL abandon the frame; no DATA_LOADED, no residual WVALID after release; first cycle after release in IDLE.

Verification
REQ-030 START, SAMP_NUMBER = 10, RVALID = 1 with RDATA = 1..10 -> RAM writes addr 0..9 data 1..10 over 10 cycles, DATA_LOADED one cycle after 10th, RREADY 0 thereafter.
REQ-031 CALC_END after load, RAM_RDATA = 100+addr, WREADY = 1 -> WDATA 100..109 every 2nd cycle, WLAST only on 109, then IDLE, BUSY = 0.
REQ-032 WREADY held low 5 cycles on word 3 -> WVALID held, WDATA = 103 stable, no extra RAM_RE.
REQ-033 SAMP_NUMBER = 0 -> ERR pulse, BUSY stays 0; SAMP_NUMBER = DEPTH+5 (ADDR_WIDTH = 3) -> exactly 8 writes, DATA_LOADED after 8th.
REQ-034 RVALID toggling 1/0 during LOAD of 4 samples -> 4 writes only on valid cycles, index gaps none.
REQ-035 n_Reset asserted in HOLD with WVALID = 1 -> WVALID 0 asynchronously; new START with SAMP_NUMBER = 1 after release -> one write, one WLAST word.

Source files
------------

// File: rtl/fft_stream_bridge.sv
// Streams one frame of samples into the FFT RAM, waits for the core, then streams the results out.
// Loads one sample per cycle; outputs one result word every 2 cycles; the output holds its word while WREADY is low.
module fft_stream_bridge #(
    parameter int IN_WIDTH   = 16,
    parameter int OUT_WIDTH  = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  n_Reset,
    input  logic                  START,
    input  logic [ADDR_WIDTH:0]   SAMP_NUMBER,
    input  logic [IN_WIDTH-1:0]   RDATA,
    input  logic                  RVALID,
    output logic                  RREADY,
    output logic [OUT_WIDTH-1:0]  WDATA,
    output logic                  WVALID,
    input  logic                  WREADY,
    output logic                  WLAST,
    output logic [ADDR_WIDTH-1:0] RAM_ADDR,
    output logic [IN_WIDTH-1:0]   RAM_WDATA,
    output logic                  RAM_WE,
    output logic                  RAM_RE,
    input  logic [OUT_WIDTH-1:0]  RAM_RDATA,
    output logic                  DATA_LOADED,
    input  logic                  CALC_END,
    output logic                  BUSY,
    output logic                  ERR
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE_C   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, LOAD, WAIT_CALC, RD, HOLD} state_t;

    state_t                state;
    logic [ADDR_WIDTH:0]   idx;
    logic [ADDR_WIDTH:0]   n_reg;
    logic [ADDR_WIDTH:0]   n_last;
    logic [OUT_WIDTH-1:0]  wdata_reg;
    logic                  hold_first;
    logic                  data_loaded;
    logic                  err;
    logic                  is_last;

    assign n_last  = n_reg - ONE_C;
    assign is_last = (idx == n_last);

    always_ff @(posedge clk or negedge n_Reset) begin
        if (!n_Reset) begin
            state       <= IDLE;
            idx         <= '0;
            n_reg       <= '0;
            wdata_reg   <= '0;
            hold_first  <= 1'b0;
            data_loaded <= 1'b0;
            err         <= 1'b0;
        end else begin
            data_loaded <= 1'b0;
            err         <= 1'b0;
            hold_first  <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        if (SAMP_NUMBER == '0) begin
                            err <= 1'b1;
                        end else begin
                            n_reg <= (SAMP_NUMBER > DEPTH_C) ? DEPTH_C : SAMP_NUMBER;
                            idx   <= '0;
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (RVALID) begin
                        if (is_last) begin
                            idx         <= '0;
                            data_loaded <= 1'b1;
                            state       <= WAIT_CALC;
                        end else begin
                            idx <= idx + ONE_C;
                        end
                    end
                end
                WAIT_CALC: begin
                    if (CALC_END) state <= RD;
                end
                RD: begin
                    hold_first <= 1'b1;
                    state      <= HOLD;
                end
                HOLD: begin
                    // RAM data is only valid on the first HOLD cycle, so latch it then
                    if (hold_first) wdata_reg <= RAM_RDATA;
                    if (WREADY) begin
                        if (is_last) begin
                            idx   <= '0;
                            state <= IDLE;
                        end else begin
                            idx   <= idx + ONE_C;
                            state <= RD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // First HOLD cycle bypasses the register so a word can leave every 2 cycles
    always_comb begin
        RREADY    = (state == LOAD);
        RAM_WE    = (state == LOAD) && RVALID;
        RAM_RE    = (state == RD);
        RAM_ADDR  = ((state == LOAD) || (state == RD)) ? idx[ADDR_WIDTH-1:0] : '0;
        RAM_WDATA = (state == LOAD) ? RDATA : '0;
        WVALID    = (state == HOLD);
        WLAST     = (state == HOLD) && is_last;
        WDATA     = (state == HOLD) ? (hold_first ? RAM_RDATA : wdata_reg) : '0;
        BUSY      = (state != IDLE);
        DATA_LOADED = data_loaded;
        ERR       = err;
    end

endmodule
